adder_error_monitor32: RTL and testbench
========================================

Name: adder_error_monitor32

Overview:
- Sequential error-statistics collector directly downstream of the 32-bit approximate adders (xnor_based_carry_lookahead_adder32 and siblings).
- Takes the same operand pair fed to the adder under test plus its 33-bit result, computes the exact sum internally and accumulates error metrics over a programmed number of samples.
- Outputs: error count (for error rate), error-distance sum (for mean error distance) and maximum error distance, for on-chip or gate-level characterisation runs.

Parameters:
- WIDTH, 32, operand width; exact sum and result are WIDTH+1 bits.
- CNT_W, 16, width of sample target and counters.
- ACC_W, 48, width of error-distance accumulator.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  begin a measurement window (sampled in IDLE only).
- num_samples_i  input  CNT_W  samples per window, latched on accepted start.
- valid_i  input  1  operand/result triple valid this cycle.
- ready_o  output  1  high only in RUN; a sample is accepted when valid_i && ready_o.
- add1_i  input  WIDTH  operand A as applied to the adder.
- add2_i  input  WIDTH  operand B as applied to the adder.
- approx_i  input  WIDTH+1  result_o of the approximate adder.
- busy_o  output  1  high in RUN or DRAIN.
- done_o  output  1  one-cycle pulse, statistics final.
- sample_cnt_o  output  CNT_W  samples accumulated.
- err_cnt_o  output  CNT_W  samples with approx_i != exact sum.
- err_sum_o  output  ACC_W  sum of error distances, saturating.
- err_max_o  output  WIDTH+1  largest error distance.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is rst_ni, asynchronous and active-low.
- Reset values:
  - All outputs, counters, accumulators and pipeline registers are 0.
  - State is IDLE.
  - Reset mid-window aborts the window; no done_o pulse.
- FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start_i=1 with num_samples_i!=0: latch target, clear all statistics and the pipeline, go to RUN on the next edge.
  - start_i with num_samples_i==0 is ignored.
  - Statistics from the previous window hold in IDLE.
- RUN:
  - ready_o=1. Each accepted sample increments the accepted-count.
  - When the accepted-count reaches the target (on the accepting edge), go to DRAIN; ready_o=0 from the next cycle.
  - Gaps in valid_i are allowed and do not advance anything.
- Pipeline, for a sample accepted at edge k:
  - Stage 1 (edge k): register exact = add1_i + add2_i (WIDTH+1 bits, zero-extended), and approx_i.
  - Stage 2 (edge k+1): register ed = |exact - approx| and mismatch flag ed!=0.
  - Stage 3 (edge k+2): sample_cnt_o += 1; err_cnt_o += flag; err_sum_o += ed, saturating at all-ones; err_max_o = max(err_max_o, ed).
  - Each stage carries its own valid bit.
- DRAIN:
  - Fixed 2 cycles. The DONE state is entered on edge k+2 of the last sample, the same edge as its accumulation.
- DONE:
  - done_o=1 for exactly one cycle; statistics final and stable. Next edge returns to IDLE.
- Boundary conditions:
  - start_i during RUN/DRAIN/DONE is ignored.
  - valid_i while ready_o=0 is dropped; it is not counted.
  - Exact sum includes carry-out; approx_i above exact is handled via absolute value.
  - Max ed is 2^(WIDTH+1)-1; err_max_o never wraps.
  - Back-to-back windows: start_i asserted in the cycle done_o is high is ignored; start_i is accepted from the IDLE cycle onward.

Test Plan:
- Exact results: start, num_samples=4; feed 4 samples with approx_i = true sum, including 0+0 and 0xFFFFFFFF+0x00000001 -> 0x1_00000000. -> done_o 2 cycles after the last accept edge; sample_cnt=4, err_cnt=0, err_sum=0, err_max=0.
- Under-estimate: num_samples=1; add1=0x29AF2430, add2=0x7A1B9ABC, approx=0x0_A3CABEE0 (exact 0x0_A3CABEEC). -> err_cnt=1, err_sum=0xC, err_max=0xC.
- Over-estimate plus max tracking: num_samples=3:
  - 0x55555555+0xAAAAAAAA with approx 0x1_00000003 (ed 4);
  - 0x1234+0 with approx 0x1234 (ed 0);
  - 0x10+0x10 with approx 0x0 (ed 0x20).
  - Required: err_cnt=2, err_sum=0x24, err_max=0x20.
- Handshake: num_samples=2; valid_i pulses separated by 3 idle cycles; then a third valid after the second accept, and start_i asserted mid-RUN. -> ready_o drops after the 2nd accept; 3rd sample is not counted; sample_cnt=2; start ignored; single done_o pulse.
- Reset/zero window: pull rst_ni low mid-RUN -> all outputs 0 immediately, no done_o. Then start with num_samples=0 -> remains IDLE, busy_o=0.

Source files
------------

// File: rtl/adder_error_monitor32_if.sv
// Sample/result bus between an approximate-adder harness and the error monitor.
// The harness drives operands, the adder result and window control; the monitor returns status and statistics.
interface adder_error_monitor32_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 48
);
    logic             start_i;
    logic [CNT_W-1:0] num_samples_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] add1_i;
    logic [WIDTH-1:0] add2_i;
    logic [WIDTH:0]   approx_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] sample_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [ACC_W-1:0] err_sum_o;
    logic [WIDTH:0]   err_max_o;

    modport master (
        output start_i, num_samples_i, valid_i, add1_i, add2_i, approx_i,
        input  ready_o, busy_o, done_o, sample_cnt_o, err_cnt_o, err_sum_o, err_max_o
    );

    modport slave (
        input  start_i, num_samples_i, valid_i, add1_i, add2_i, approx_i,
        output ready_o, busy_o, done_o, sample_cnt_o, err_cnt_o, err_sum_o, err_max_o
    );
endinterface

// File: rtl/adder_error_monitor32.sv
// Error-statistics collector for approximate adders: compares each result with the exact sum
// over a programmed number of samples and accumulates error count, distance sum and maximum.
module adder_error_monitor32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 48
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    adder_error_monitor32_if.slave bus
);
    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned EXT_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic             drain_q;
    logic             ready_q, busy_q, done_q;

    logic [SUM_W-1:0] s1_exact_q, s1_approx_q;
    logic             s1_vld_q;
    logic [SUM_W-1:0] s2_ed_q;
    logic             s2_err_q, s2_vld_q;

    logic [CNT_W-1:0] sample_cnt_q, err_cnt_q;
    logic [ACC_W-1:0] err_sum_q;
    logic [SUM_W-1:0] err_max_q;

    logic             launch_c, accept_c, last_c;
    logic [EXT_W-1:0] sum_ext_c;

    assign launch_c  = (state_q == IDLE) && bus.start_i && (bus.num_samples_i != '0);
    assign accept_c  = bus.valid_i && ready_q;
    assign last_c    = accept_c && ((acc_cnt_q + CNT_W'(1)) == target_q);
    assign sum_ext_c = {1'b0, err_sum_q} + EXT_W'(s2_ed_q);

    // Next-state logic; DRAIN covers the two pipeline stages behind the last accept
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (launch_c) state_nxt = RUN;
            RUN:     if (last_c) state_nxt = DRAIN;
            DRAIN:   if (drain_q) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, registered status outputs and window bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drain_q   <= 1'b0;
            target_q  <= '0;
            acc_cnt_q <= '0;
        end else begin
            state_q <= state_nxt;
            ready_q <= (state_nxt == RUN);
            busy_q  <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done_q  <= (state_nxt == DONE);
            drain_q <= (state_q == DRAIN) && (state_nxt == DRAIN);
            if (launch_c) begin
                target_q  <= bus.num_samples_i;
                acc_cnt_q <= '0;
            end else if (accept_c) begin
                acc_cnt_q <= acc_cnt_q + CNT_W'(1);
            end
        end
    end

    // Three-stage datapath: exact sum, error distance, accumulation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q     <= 1'b0;
            s1_exact_q   <= '0;
            s1_approx_q  <= '0;
            s2_vld_q     <= 1'b0;
            s2_ed_q      <= '0;
            s2_err_q     <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_sum_q    <= '0;
            err_max_q    <= '0;
        end else if (launch_c) begin
            s1_vld_q     <= 1'b0;
            s1_exact_q   <= '0;
            s1_approx_q  <= '0;
            s2_vld_q     <= 1'b0;
            s2_ed_q      <= '0;
            s2_err_q     <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_sum_q    <= '0;
            err_max_q    <= '0;
        end else begin
            s1_vld_q <= accept_c;
            if (accept_c) begin
                s1_exact_q  <= SUM_W'(bus.add1_i) + SUM_W'(bus.add2_i);
                s1_approx_q <= bus.approx_i;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_ed_q  <= (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                                        : (s1_approx_q - s1_exact_q);
                s2_err_q <= (s1_exact_q != s1_approx_q);
            end
            if (s2_vld_q) begin
                sample_cnt_q <= sample_cnt_q + CNT_W'(1);
                err_cnt_q    <= err_cnt_q + CNT_W'(s2_err_q);
                err_sum_q    <= sum_ext_c[ACC_W] ? '1 : sum_ext_c[ACC_W-1:0];
                if (s2_ed_q > err_max_q) err_max_q <= s2_ed_q;
            end
        end
    end

    assign bus.ready_o      = ready_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.sample_cnt_o = sample_cnt_q;
    assign bus.err_cnt_o    = err_cnt_q;
    assign bus.err_sum_o    = err_sum_q;
    assign bus.err_max_o    = err_max_q;
endmodule

// File: tb/tb_adder_error_monitor32.sv
// Directed bench for adder_error_monitor32: a reference model queues expected window statistics
// as samples are driven; they are popped and compared when done_o pulses.
module tb_adder_error_monitor32;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned ACC_W = 48;

    typedef struct {
        logic [CNT_W-1:0] smp;
        logic [CNT_W-1:0] err;
        logic [ACC_W-1:0] sum;
        logic [WIDTH:0]   mx;
    } stats_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     checks = 0;
    int     failures = 0;
    stats_t exp_q[$];
    stats_t run;

    adder_error_monitor32_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

    adder_error_monitor32 #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [WIDTH:0] ref_ed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH:0] ap);
        logic [WIDTH:0] exact;
        exact = {1'b0, a} + {1'b0, b};
        return (exact > ap) ? exact - ap : ap - exact;
    endfunction

    task automatic start_window(input logic [CNT_W-1:0] n);
        run = '{smp: '0, err: '0, sum: '0, mx: '0};
        bus.start_i       = 1'b1;
        bus.num_samples_i = n;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("start_busy", 64'(bus.busy_o), 64'h1);
        check("start_ready", 64'(bus.ready_o), 64'h1);
        check("start_clr_smp", 64'(bus.sample_cnt_o), 64'h0);
        check("start_clr_max", 64'(bus.err_max_o), 64'h0);
    endtask

    task automatic drive_sample(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH:0] ap);
        logic [WIDTH:0] ed;
        bus.add1_i   = a;
        bus.add2_i   = b;
        bus.approx_i = ap;
        bus.valid_i  = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        ed = ref_ed(a, b, ap);
        run.smp = run.smp + 16'd1;
        if (ed != '0) run.err = run.err + 16'd1;
        run.sum = run.sum + 48'(ed);
        if (ed > run.mx) run.mx = ed;
    endtask

    // Wait for done_o, compare against the queued expectation, then probe start during DONE
    task automatic finish_window(input int lat);
        int     n;
        stats_t e;
        exp_q.push_back(run);
        n = 0;
        while (!bus.done_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("done_latency", 64'(n), 64'(lat));
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'h1, 64'h0);
        end else begin
            e = exp_q.pop_front();
            check("sample_cnt", 64'(bus.sample_cnt_o), 64'(e.smp));
            check("err_cnt", 64'(bus.err_cnt_o), 64'(e.err));
            check("err_sum", 64'(bus.err_sum_o), 64'(e.sum));
            check("err_max", 64'(bus.err_max_o), 64'(e.mx));
        end
        bus.start_i       = 1'b1;
        bus.num_samples_i = 16'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("done_single", 64'(bus.done_o), 64'h0);
        check("start_in_done_ignored", 64'(bus.busy_o), 64'h0);
        check("stats_hold", 64'(bus.sample_cnt_o), 64'(run.smp));
    endtask

    initial begin
        int pulses;
        bus.start_i       = 1'b0;
        bus.num_samples_i = '0;
        bus.valid_i       = 1'b0;
        bus.add1_i        = '0;
        bus.add2_i        = '0;
        bus.approx_i      = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy_o), 64'h0);
        check("rst_ready", 64'(bus.ready_o), 64'h0);
        check("rst_done", 64'(bus.done_o), 64'h0);
        check("rst_sum", 64'(bus.err_sum_o), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Exact results
        start_window(16'd4);
        drive_sample(32'h0, 32'h0, 33'h0);
        drive_sample(32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
        drive_sample(32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789);
        drive_sample(32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000);
        check("ready_drop", 64'(bus.ready_o), 64'h0);
        finish_window(2);
        check("exact_err_cnt", 64'(bus.err_cnt_o), 64'h0);

        // Under-estimate, launched from the first IDLE cycle after DONE
        start_window(16'd1);
        drive_sample(32'h29AF_2430, 32'h7A1B_9ABC, 33'h0_A3CA_BEE0);
        finish_window(2);
        check("under_err_sum", 64'(bus.err_sum_o), 64'hC);
        check("under_err_max", 64'(bus.err_max_o), 64'hC);

        // Over-estimate plus max tracking
        start_window(16'd3);
        drive_sample(32'h5555_5555, 32'hAAAA_AAAA, 33'h1_0000_0003);
        drive_sample(32'h0000_1234, 32'h0, 33'h0_0000_1234);
        drive_sample(32'h0000_0010, 32'h0000_0010, 33'h0);
        finish_window(2);
        check("over_err_cnt", 64'(bus.err_cnt_o), 64'h2);
        check("over_err_sum", 64'(bus.err_sum_o), 64'h24);
        check("over_err_max", 64'(bus.err_max_o), 64'h20);

        // Largest possible error distances
        start_window(16'd2);
        drive_sample(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0);
        drive_sample(32'h0, 32'h0, 33'h1_FFFF_FFFF);
        finish_window(2);
        check("max_ed", 64'(bus.err_max_o), 64'h1_FFFF_FFFF);
        check("max_sum", 64'(bus.err_sum_o), 64'h3_FFFF_FFFD);

        // Handshake: gaps, start mid-RUN, valid after the final accept
        start_window(16'd2);
        drive_sample(32'h0000_0003, 32'h0000_0004, 33'h0_0000_0006);
        repeat (3) @(negedge clk);
        check("gap_sample_cnt", 64'(bus.sample_cnt_o), 64'h1);
        bus.start_i       = 1'b1;
        bus.num_samples_i = 16'd9;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("start_mid_run_ready", 64'(bus.ready_o), 64'h1);
        drive_sample(32'h0000_0100, 32'h0000_0001, 33'h0_0000_0101);
        check("hs_ready_drop", 64'(bus.ready_o), 64'h0);
        bus.add1_i   = 32'h0000_0500;
        bus.add2_i   = 32'h0;
        bus.approx_i = 33'h0;
        bus.valid_i  = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        finish_window(1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done_o) pulses++;
        end
        check("hs_extra_done", 64'(pulses), 64'h0);
        check("hs_sample_cnt", 64'(bus.sample_cnt_o), 64'h2);

        // Reset mid-window
        start_window(16'd5);
        drive_sample(32'h1, 32'h1, 33'h0);
        repeat (2) @(negedge clk);
        check("pre_rst_err_cnt", 64'(bus.err_cnt_o), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy_o), 64'h0);
        check("arst_ready", 64'(bus.ready_o), 64'h0);
        check("arst_smp", 64'(bus.sample_cnt_o), 64'h0);
        check("arst_err", 64'(bus.err_cnt_o), 64'h0);
        check("arst_sum", 64'(bus.err_sum_o), 64'h0);
        check("arst_max", 64'(bus.err_max_o), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done_o) pulses++;
        end
        check("arst_no_done", 64'(pulses), 64'h0);

        // Zero-sample start is ignored
        bus.start_i       = 1'b1;
        bus.num_samples_i = 16'd0;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("zero_busy", 64'(bus.busy_o), 64'h0);
        check("zero_ready", 64'(bus.ready_o), 64'h0);
        @(negedge clk);
        check("zero_busy_later", 64'(bus.busy_o), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
